// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the radix-2 SDF FFT pipeline: stage
//                state encoding, Q2.6 table of W_32^k and a HALF legality
//                check.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Stage controller states; the encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BFLY  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_FILL  = 2'b11
    } stage_state_t;

    // Unity twiddle used for every slot that is not a drain slot.
    localparam logic [7:0] UNITY_RE = 8'h40;
    localparam logic [7:0] UNITY_IM = 8'h00;

    // W_32^k = cos(2*pi*k/32) - j*sin(2*pi*k/32) in Q2.6, rounded toward -inf.
    localparam logic [7:0] TW_RE [16] = '{
        8'h40, 8'h3E, 8'h3B, 8'h35, 8'h2D, 8'h23, 8'h18, 8'h0C,
        8'h00, 8'hF3, 8'hE7, 8'hDC, 8'hD2, 8'hCA, 8'hC4, 8'hC1
    };
    localparam logic [7:0] TW_IM [16] = '{
        8'h00, 8'hF3, 8'hE7, 8'hDC, 8'hD2, 8'hCA, 8'hC4, 8'hC1,
        8'hC0, 8'hC1, 8'hC4, 8'hCA, 8'hD2, 8'hDC, 8'hE7, 8'hF3
    };

    // A stage of a 32-point FFT has a half-length that is a power of two <= 16.
    function automatic bit half_is_legal(input int half);
        return (half == 1) || (half == 2) || (half == 4) || (half == 8) || (half == 16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_stage_ctrl_if
//  Description : Sample stream in, butterfly control and twiddle out, for one
//                SDF stage controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdf_stage_ctrl_if;

    logic              valid_i;
    logic signed [7:0] data_in_r;
    logic signed [7:0] data_in_i;
    logic              valid_o;
    logic [1:0]        state;
    logic              bf_en;
    logic signed [7:0] data_out_r;
    logic signed [7:0] data_out_i;
    logic signed [7:0] WN_r;
    logic signed [7:0] WN_i;
    logic              frame_err;

    // Upstream side: supplies samples, observes the controller outputs.
    modport master (
        output valid_i, data_in_r, data_in_i,
        input  valid_o, state, bf_en, data_out_r, data_out_i, WN_r, WN_i, frame_err
    );

    // Controller side.
    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output valid_o, state, bf_en, data_out_r, data_out_i, WN_r, WN_i, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/sdf_stage_ctrl_twiddle_rom.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_rom
//  Description : Combinational lookup of W_32^idx (Q2.6, real/imag).
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_rom
    import fft_pkg::*;
(
    input  wire logic [3:0] idx,
    output logic      [7:0] wn_r,
    output logic      [7:0] wn_i
);

    // Plain table read; the caller registers the result.
    always_comb begin
        wn_r = TW_RE[idx];
        wn_i = TW_IM[idx];
    end

endmodule
`default_nettype wire

// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_stage_ctrl
//  Description : Control unit of one radix-2 SDF stage. Classifies each
//                sample as fill / butterfly / drain, drives the butterfly
//                enable and the stage twiddle W_(2*HALF)^p, and forwards the
//                input stream to butterfly port A. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int HALF = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sdf_stage_ctrl_if.slave bus
);

    localparam int            PW      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    // Drain phase p maps onto W_32^(p*STRIDE).
    localparam int            STRIDE  = 16 / HALF;

    // Refuse to elaborate with a half-length that has no place in a 32-point FFT.
    generate
        if (!half_is_legal(HALF)) begin : g_half_illegal
            $error("sdf_stage_ctrl: HALF must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    stage_state_t      state;
    logic [PW-1:0]     ph;
    logic              nxt;       // next frame is filling during this drain
    logic              drop;      // drain already flagged; ignore input until IDLE

    logic              valid_o_q;
    logic              bf_en_q;
    logic              frame_err_q;
    logic [7:0]        data_out_r_q;
    logic [7:0]        data_out_i_q;
    logic [7:0]        wn_r_q;
    logic [7:0]        wn_i_q;

    logic              ph_last;
    logic              ph_zero;
    logic              bfly_slot;
    logic              drain_slot;
    logic              frame_abort;
    logic              drain_viol;
    logic              nxt_eff;
    logic [3:0]        rom_idx;
    logic [7:0]        rom_r;
    logic [7:0]        rom_i;

    twiddle_rom u_twiddle_rom (
        .idx  (rom_idx),
        .wn_r (rom_r),
        .wn_i (rom_i)
    );

    // Slot decode for the current cycle and protocol checks.
    always_comb begin
        ph_last     = (ph == PH_LAST);
        ph_zero     = (ph == '0);
        bfly_slot   = (state == ST_BFLY) && bus.valid_i;
        drain_slot  = (state == ST_DRAIN);
        frame_abort = ((state == ST_FILL) || (state == ST_BFLY)) && !bus.valid_i;
        // At ph=0 the next-frame flag is being sampled, so nothing can mismatch yet.
        drain_viol  = drain_slot && !ph_zero && !drop && (bus.valid_i != nxt);
        // At ph=0 nxt is not registered yet; matters when HALF=1 (ph=0 is also last).
        nxt_eff     = ph_zero ? bus.valid_i : nxt;
        rom_idx     = 4'(int'(ph) * STRIDE);
    end

    // State machine plus registered outputs describing the current slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ph           <= '0;
            nxt          <= 1'b0;
            drop         <= 1'b0;
            valid_o_q    <= 1'b0;
            bf_en_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            data_out_r_q <= '0;
            data_out_i_q <= '0;
            wn_r_q       <= UNITY_RE;
            wn_i_q       <= UNITY_IM;
        end else begin
            valid_o_q    <= bfly_slot || drain_slot;
            bf_en_q      <= bfly_slot;
            frame_err_q  <= frame_abort || drain_viol;
            data_out_r_q <= bus.data_in_r;
            data_out_i_q <= bus.data_in_i;
            if (drain_slot) begin
                wn_r_q <= rom_r;
                wn_i_q <= rom_i;
            end else begin
                wn_r_q <= UNITY_RE;
                wn_i_q <= UNITY_IM;
            end

            case (state)
                ST_IDLE: begin
                    nxt  <= 1'b0;
                    drop <= 1'b0;
                    ph   <= '0;
                    if (bus.valid_i) begin
                        // This cycle is fill slot 0.
                        if (HALF == 1) begin
                            state <= ST_BFLY;
                        end else begin
                            state <= ST_FILL;
                            ph    <= PH_ONE;
                        end
                    end
                end
                ST_FILL: begin
                    if (!bus.valid_i) begin
                        state <= ST_IDLE;
                        ph    <= '0;
                    end else if (ph_last) begin
                        state <= ST_BFLY;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                ST_BFLY: begin
                    if (!bus.valid_i) begin
                        state <= ST_IDLE;
                        ph    <= '0;
                    end else if (ph_last) begin
                        state <= ST_DRAIN;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ph_zero) begin
                        nxt <= bus.valid_i;
                    end
                    if (drain_viol) begin
                        nxt  <= 1'b0;
                        drop <= 1'b1;
                    end
                    if (ph_last) begin
                        ph    <= '0;
                        nxt   <= 1'b0;
                        drop  <= 1'b0;
                        state <= (nxt_eff && !drain_viol) ? ST_BFLY : ST_IDLE;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ph    <= '0;
                    nxt   <= 1'b0;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state      = state;
    assign bus.valid_o    = valid_o_q;
    assign bus.bf_en      = bf_en_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.data_out_r = data_out_r_q;
    assign bus.data_out_i = data_out_i_q;
    assign bus.WN_r       = wn_r_q;
    assign bus.WN_i       = wn_i_q;

endmodule
`default_nettype wire

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Parameterised control unit for one radix-2 single-path delay-feedback (SDF) stage of the 32-point FFT pipeline. It classifies each incoming sample as fill, butterfly or drain, and drives the butterfly enable, the shift-register input mux select and the stage twiddle factor W_N^n (N = 2·HALF). It also registers the sample stream into butterfly port A. One instance sits in front of every stage's butterfly/shift-register pair, and it supports back-to-back frames.

## Interface
- HALF, 8: stage half-length and delay-line depth; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  sample qualifier; must stay high for the 2·HALF samples of a frame.
- data_in_r / data_in_i  in  8 each  signed input sample.
- valid_o  out  1  stage output valid, aligned with data_out.
- state  out  2  current state register.
- bf_en  out  1  butterfly mode: output a+b, store a−b in delay line; 0 means delay line is fed from the input.
- data_out_r / data_out_i  out  8 each  data_in delayed one cycle, to butterfly port A.
- WN_r / WN_i  out  8 each  signed twiddle, Q2.6.
- frame_err  out  1  one-cycle pulse on frame protocol violation.

## Operation
- States use the fixed encoding IDLE=00, BFLY=01, DRAIN=10, FILL=11.
- A phase counter ph runs 0..HALF−1 and wraps at each state change.
- Every cycle has a slot (fill / bfly / drain / none) with a slot phase.
- IDLE, valid_i=1: fill slot, phase 0. Next state is FILL with ph=1, or BFLY with ph=0 when HALF=1.
- FILL: fill slots 1..HALF−1. At ph=HALF−1 the next state is BFLY.
- BFLY: bfly slots 0..HALF−1. At ph=HALF−1 the next state is DRAIN.
- DRAIN: drain slots 0..HALF−1. Internal flag nxt is set to valid_i at ph=0.
  - If nxt=1, each DRAIN cycle is also a fill slot of the next frame.
  - At ph=HALF−1 the next state is BFLY if nxt=1, otherwise IDLE.
- Violation in FILL or BFLY (valid_i=0): frame_err pulses, next state is IDLE, the partial frame is discarded.
- Violation in DRAIN (valid_i ≠ nxt at ph>0): frame_err pulses and nxt clears. The current drain completes, then the block goes to IDLE. Input is ignored until IDLE.
- valid_i=1 arriving during DRAIN at ph>0 while nxt=0 is a violation, handled as above.
- Twiddle for drain slot phase p is W_{2·HALF}^p = W_32^(p·16/HALF). Non-drain slots output unity (0x40, 0x00).

## Timing
- All outputs are registered. The outputs at edge t+1 describe the slot at cycle t.
- valid_o = 1 for a bfly or drain slot.
- bf_en = 1 for a bfly slot.
- data_out = data_in of cycle t.
- Latency:
  - First sample at cycle 0.
  - First g output at cycle HALF+1.
  - First h·W output at cycle 2·HALF+1.
  - Last output at cycle 3·HALF.
- Back-to-back frames: frame k+1 sample 0 arrives at cycle 2·HALF. valid_o then stays high continuously.
- frame_err is registered and appears one cycle after the offending sample.
- Reset values, on the edge where rst=1:
  - state=IDLE, ph=0, nxt=0.
  - valid_o, bf_en, frame_err = 0.
  - data_out = 0, WN = 0x40 / 0x00.
- rst mid-frame aborts the frame without asserting frame_err.
- rst takes priority over all transitions.

## Structure
- Shared package fft_pkg:
  - state encoding constants.
  - Q2.6 table of W_32^k for k=0..15, e.g. k=4: 0x2D/0xD2; k=8: 0x00/0xC0.
  - HALF legality check function.
- One sub-module, twiddle_rom: combinational lookup from a 4-bit W_32 index to WN_r/WN_i. The controller registers its output.

## Test plan
- Single frame, HALF=8, valid_i high for 16 cycles from cycle 0:
  - valid_o high at cycles 9..24; bf_en high at 9..16.
  - Cycle 17: WN 0x40/0x00. Cycle 19: 0x2D/0xD2. Cycle 21: 0x00/0xC0.
  - state returns to 00 at cycle 24.
- Back-to-back: three frames with valid_i high for 48 cycles, HALF=8.
  - valid_o continuously high from cycle 9 to 56; no frame_err.
- valid_i dropped at cycle 5, HALF=8.
  - frame_err pulses at cycle 6, state=IDLE at cycle 6, valid_o never rises.
- valid_i rises at drain phase 3 of a single frame (HALF=8).
  - frame_err pulse; drain completes with valid_o high through cycle 24; then IDLE.
- HALF=1: valid_i high for 2 cycles.
  - bf_en=1 at cycle 2; WN 0x40/0x00 at cycle 3; valid_o high at cycles 2..3.
- rst asserted at cycle 12 of a HALF=8 frame.
  - Next edge: all outputs at reset values; a frame started later behaves as in the first scenario.
